gcd_engine: RTL and testbench
=============================

# gcd_engine

Parametrised, self-contained Euclid-by-subtraction GCD unit: controller FSM plus WIDTH-bit datapath in one block, with a start/busy/done handshake, abort, and zero-operand handling. Next-generation replacement for the fixed-width controller/datapath pair in the GCD subsystem. A host drives operands and start, then reads result on done.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; clears all state and outputs immediately
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous cancel; effective in RUN only
- a_in  in  WIDTH  operand A, captured on accepting edge
- b_in  in  WIDTH  operand B, captured on accepting edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  GCD; held from done until next accepted start
- iterations  out  WIDTH  subtraction count (only with GCD_ITER_COUNT_EN)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: busy=0, done=0, result=0, iterations=0, internal x=y=0.
- IDLE: start=1 at edge → x←a_in, y←b_in, iter←0, state←RUN. start=0 → stay.
- RUN, per edge, priority order:
  - abort=1 → IDLE; result, iterations unchanged; no done.
  - x==y, x==0 or y==0 → result←(x==0 ? y : x), iterations←iter, state←DONE.
  - x>y → x←x−y, iter+1; else y←y−x, iter+1; stay RUN.
- DONE: done=1 for that cycle; next edge → IDLE unconditionally.
- start in RUN or DONE ignored (not queued); abort in IDLE or DONE ignored.
- Arithmetic unsigned, WIDTH bits; subtraction always larger minus smaller, no underflow. Termination guaranteed by the zero checks.
- gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0; all take zero subtractions.
- a_in/b_in changes after the accepting edge have no effect.

## Timing
- busy, done and result registered; no combinational input-to-output path.
- k = number of subtractions. Accepting edge E0; terminal detection at E0+k+1; done high for exactly the cycle after E0+k+1; busy high for cycles after E0 through E0+k+1 (k+1 cycles), low in DONE.
- Max k = 2^WIDTH − 2 (operands all-ones and 1); iter counter never wraps.
- Back-to-back: earliest next accept is the edge after the DONE cycle (IDLE); throughput k+3 cycles per op.
- reset_n assertion mid-RUN: outputs cleared without waiting for clock; after deassertion, block sits in IDLE; no done.

## Configuration
- GCD_ITER_COUNT_EN defined: iterations port present, loaded with k on the RUN→DONE edge, held until next DONE or reset; abort leaves it unchanged.
- Not defined: port and counter removed; all other behaviour and timing identical.

## Test plan
- WIDTH=16, a=12, b=8, start one cycle → busy 3 cycles, done pulse 3 edges after accept, result=4, iterations=2.
- a=0, b=0 then a=0, b=5 then a=7, b=7 → result 0, 5, 7 respectively; each done 1 edge after accept; iterations=0.
- WIDTH=8, a=255, b=1 → result=1, iterations=254, done 255 edges after accept; no overflow.
- a=48, b=18 accepted; start with a=9, b=3 pulsed mid-RUN → ignored; result=6, iterations=4.
- a=100, b=1 accepted; abort at third RUN cycle → IDLE next edge, no done, result keeps prior value; fresh start a=9, b=6 → result=3.
- reset_n low mid-RUN between clock edges → busy, done, result, iterations 0 immediately; release, start a=21, b=14 → result=7.

Source files
------------

// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD engine: IDLE/RUN/DONE controller and WIDTH-bit datapath.
// Optional GCD_ITER_COUNT_EN adds the iterations port and subtraction counter.
module gcd_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iterations
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] result_d;
  logic             busy_d;
  logic             done_d;
  logic             terminal;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_q, iter_d;
  logic [WIDTH-1:0] iterations_d;
`endif

  // Either operand zero or both equal ends the subtraction loop.
  assign terminal = (x_q == y_q) || (x_q == '0) || (y_q == '0);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef GCD_ITER_COUNT_EN
    iter_d       = iter_q;
    iterations_d = iterations;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = a_in;
          y_d     = b_in;
          state_d = RUN;
          busy_d  = 1'b1;
`ifdef GCD_ITER_COUNT_EN
          iter_d  = '0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (terminal) begin
          result_d = (x_q == '0) ? y_q : x_q;
          state_d  = DONE;
          done_d   = 1'b1;
`ifdef GCD_ITER_COUNT_EN
          iterations_d = iter_q;
`endif
        end else begin
          busy_d = 1'b1;
          if (x_q > y_q) begin
            x_d = x_q - y_q;
          end else begin
            y_d = y_q - x_q;
          end
`ifdef GCD_ITER_COUNT_EN
          iter_d = iter_q + WIDTH'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
      iter_q     <= '0;
      iterations <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      result  <= result_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef GCD_ITER_COUNT_EN
      iter_q     <= iter_d;
      iterations <= iterations_d;
`endif
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed-vector bench for gcd_engine (16-bit instance plus an 8-bit instance for the long run).
module tb_gcd_engine;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  result8;

`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iterations;
  logic [7:0]  iterations8;
`endif

  int checks = 0;
  int errors = 0;

  gcd_engine #(.WIDTH(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .result     (result)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iterations (iterations)
`endif
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start8),
    .abort      (abort),
    .a_in       (a8),
    .b_in       (b8),
    .busy       (busy8),
    .done       (done8),
    .result     (result8)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iterations (iterations8)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          k;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accept one operation, optionally pulse a stray start at RUN cycle inject, and measure it.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input int inject, input logic [15:0] exp_res, input int exp_k);
    int lat;
    int busyc;
    lat   = 0;
    busyc = 0;
    @(negedge clock);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a_in  = 16'hFFFF;
    b_in  = 16'h0003;
    if (busy) busyc++;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busyc++;
      if (n == inject) begin
        start = 1'b1;
        a_in  = 16'd9;
        b_in  = 16'd3;
      end
    end
    check({name, " result"}, 32'(result), 32'(exp_res));
    check({name, " done_latency"}, 32'(lat), 32'(exp_k + 1));
    check({name, " busy_cycles"}, 32'(busyc), 32'(exp_k + 1));
`ifdef GCD_ITER_COUNT_EN
    check({name, " iterations"}, 32'(iterations), 32'(exp_k));
`endif
    @(posedge clock);
    #1;
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    @(posedge clock);
    #1;
    check({name, " idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat8;
    vecs[0] = '{a: 16'd12,  b: 16'd8,  res: 16'd4,  k: 2};
    vecs[1] = '{a: 16'd0,   b: 16'd0,  res: 16'd0,  k: 0};
    vecs[2] = '{a: 16'd0,   b: 16'd5,  res: 16'd5,  k: 0};
    vecs[3] = '{a: 16'd7,   b: 16'd7,  res: 16'd7,  k: 0};
    vecs[4] = '{a: 16'd9,   b: 16'd0,  res: 16'd9,  k: 0};
    vecs[5] = '{a: 16'd100, b: 16'd75, res: 16'd25, k: 3};
    vecs[6] = '{a: 16'd1,   b: 16'd16, res: 16'd1,  k: 15};
    vecs[7] = '{a: 16'd17,  b: 16'd5,  res: 16'd1,  k: 6};
    vecs[8] = '{a: 16'd21,  b: 16'd14, res: 16'd7,  k: 2};

    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    start8  = 1'b0;
    a8      = '0;
    b8      = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check("reset iterations", 32'(iterations), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, -1, vecs[i].res, vecs[i].k);
    end

    // Stray start mid-RUN must neither disturb the operands nor be queued.
    run_op("start_ignored", 16'd48, 16'd18, 2, 16'd6, 4);

    // Abort on the third RUN cycle: back to IDLE, previous result kept, no done.
    @(negedge clock);
    a_in  = 16'd100;
    b_in  = 16'd1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result_kept", 32'(result), 32'd6);
`ifdef GCD_ITER_COUNT_EN
    check("abort iterations_kept", 32'(iterations), 32'd4);
`endif
    for (int n = 0; n < 4; n++) begin
      check("abort no_done", 32'(done), 32'd0);
      @(posedge clock);
      #1;
    end
    run_op("after_abort", 16'd9, 16'd6, -1, 16'd3, 2);

    // Asynchronous reset between edges while running.
    @(negedge clock);
    a_in  = 16'd100;
    b_in  = 16'd1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst result", 32'(result), 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check("async_rst iterations", 32'(iterations), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post_rst idle busy", 32'(busy), 32'd0);
    check("post_rst idle done", 32'(done), 32'd0);
    run_op("after_reset", 16'd21, 16'd14, -1, 16'd7, 2);

    // Worst case at WIDTH=8: 255 and 1 takes 254 subtractions.
    lat8 = 0;
    @(negedge clock);
    a8     = 8'd255;
    b8     = 8'd1;
    start8 = 1'b1;
    @(posedge clock);
    #1;
    start8 = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clock);
      #1;
      if (done8) begin
        lat8 = n;
        break;
      end
    end
    check("w8 done_latency", 32'(lat8), 32'd255);
    check("w8 result", 32'(result8), 32'd1);
`ifdef GCD_ITER_COUNT_EN
    check("w8 iterations", 32'(iterations8), 32'd254);
`endif
    @(posedge clock);
    #1;
    check("w8 done_one_cycle", 32'(done8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
